// File: rtl/tuner_sequencer.sv
// Tuner command sequencer: divides clk into the I2C controller's 4x-bit-rate
// enable and issues the power-up (W0,W1,W2) and channel-tune (W2) write sequences.
// Optional ack timeout: define TUNER_SEQ_TIMEOUT_EN.
module tuner_sequencer #(
   parameter int          CLK_DIV       = 125,
   parameter logic [6:0]  I2C_ADDR      = 7'h10,
   parameter logic [15:0] GAP_TICKS     = 16'd400,
   parameter logic [15:0] TIMEOUT_TICKS = 16'd200
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            tune,
   input  logic [9:0]      channel,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            en,
   output logic [6:0]      addr,
   output logic [1:0][7:0] wdata,
   output logic            req,
   input  logic            ack
);

`ifdef TUNER_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] LOAD     = 3'd1;
   localparam logic [2:0] REQ      = 3'd2;
   localparam logic [2:0] WAIT_ACK = 3'd3;
   localparam logic [2:0] GAP      = 3'd4;
   localparam logic [2:0] FINISH   = 3'd5;
   localparam logic [2:0] ERR      = 3'd6;

   logic [2:0]    state, nxt;
   logic [DW-1:0] div;
   logic [15:0]   tick, tick_inc;
   logic [1:0]    idx;
   logic          pend;
   logic [9:0]    chq;
   logic [15:0]   word;
   logic          gap_hit, to_hit;

   assign en   = (div == DIV_MAX);
   assign busy = (state != IDLE);
   assign req  = (state == REQ);
   assign done = (state == FINISH);
   assign err  = TO_EN && (state == ERR);

   // Tick counter saturates so a long-stalled controller never looks freshly started.
   assign tick_inc = (tick == 16'hFFFF) ? tick : tick + 16'd1;
   // Decided on the en edge that brings the count to the limit, not a cycle later.
   assign gap_hit  = (tick >= GAP_TICKS) || (en && (tick_inc >= GAP_TICKS));
   assign to_hit   = en && (tick_inc >= TIMEOUT_TICKS);

   always_comb begin
      word = {chq, 6'b010000};
      case (idx)
         2'd0:    word = 16'h0002;
         2'd1:    word = 16'hC001;
         default: word = {chq, 6'b010000};
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (start || tune || pend) nxt = LOAD;
         LOAD:     nxt = REQ;
         REQ:      nxt = WAIT_ACK;
         WAIT_ACK: begin
            // A same-cycle ack beats expiry.
            if (ack)                  nxt = (idx == 2'd2) ? FINISH : GAP;
            else if (TO_EN && to_hit) nxt = ERR;
         end
         GAP:      if (gap_hit) nxt = LOAD;
         FINISH:   nxt = IDLE;
         ERR:      nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         div   <= '0;
         tick  <= '0;
         idx   <= '0;
         pend  <= 1'b0;
         chq   <= '0;
         addr  <= '0;
         wdata <= '0;
      end else begin
         div   <= en ? '0 : div + 1'b1;
         state <= nxt;

         // Channel is captured when a tune is serviced, not when it is queued.
         if (state == ERR) begin
            pend <= 1'b0;
         end else if (state == IDLE) begin
            if (start) begin
               idx  <= 2'd0;
               pend <= pend | tune;
            end else if (tune || pend) begin
               chq  <= channel;
               idx  <= 2'd2;
               pend <= 1'b0;
            end
         end else if (tune) begin
            pend <= 1'b1;
         end

         case (state)
            LOAD: begin
               addr  <= I2C_ADDR;
               wdata <= word;
            end
            REQ: tick <= '0;
            WAIT_ACK: begin
               if (ack) begin
                  if (idx != 2'd2) begin
                     idx  <= idx + 2'd1;
                     tick <= '0;
                  end
               end else if (en) begin
                  tick <= tick_inc;
               end
            end
            GAP: if (en) tick <= tick_inc;
            default: ;
         endcase
      end
   end

endmodule
